seven_seg_mux: RTL and testbench
================================

# seven_seg_mux

Parametrised, time-multiplexed driver for a multi-digit common-anode seven-segment display. It snapshots a packed nibble vector on a load strobe and scans one digit per refresh slot, driving active-low segments and anodes. Optional hex glyphs, per-digit decimal points, leading-zero suppression and a one-cycle anti-ghost guard are provided. It sits between status/FIFO-count logic and the board display pins.

## Interface
- `DIGITS`, default 4: number of digits, 1–8.
- `REFRESH_DIV`, default 100000: clocks per digit slot, ≥ 2. The counter width is `$clog2(REFRESH_DIV)`.
- `HEX_EN`, default 1: 1 shows A–F glyphs; 0 blanks nibbles A–F.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `value` input, `4*DIGITS` bits: nibble i (`value[4i+3:4i]`) is digit i; digit 0 is rightmost and least significant.
- `dp_in` input, `DIGITS` bits: decimal point request per digit, active-high.
- `blank_lz` input, 1 bit: enables leading-zero suppression. Sampled with `load`.
- `load` input, 1 bit: single-cycle strobe that captures `value`, `dp_in` and `blank_lz` into the snapshot.
- `an` output, `DIGITS` bits: anode enables, active-low, registered.
- `seg` output, 7 bits: `{a,b,c,d,e,f,g}`, active-low, registered.
- `dp` output, 1 bit: decimal point, active-low, registered.

## Operation
- **Snapshot.** When `load=1` at an edge, the snapshot registers take `value`, `dp_in` and `blank_lz`. With no load, the snapshot holds. Display data comes only from the snapshot, so a scan never shows a partial update.
- **Slot counter.** `cnt` counts 0..`REFRESH_DIV`-1.
  - At terminal count, `cnt` returns to 0 and `idx` advances.
  - `idx` wraps from `DIGITS`-1 to 0.
- **Guard cycle.** When `cnt==0`, the next outputs are `an` all-ones, `seg=7'h7F` and `dp=1`.
- **Active cycles.** When `cnt≥1`:
  - `an` has bit `idx` low and all other bits high.
  - `seg` is the glyph for snapshot nibble `idx`.
  - `dp` is `~snap_dp[idx]`.
- **Glyphs** (`seg`, bit order a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - With `HEX_EN=0`, nibbles A–F give 1111111.
- **Leading-zero suppression.** When `snap_blank_lz=1`, digit i (i≥1) is suppressed if all nibbles i..`DIGITS`-1 are zero.
  - A suppressed digit drives `an` all-ones, `seg=7'h7F` and `dp=1`, even if its dp is requested.
  - Digit 0 is never suppressed.
- **Reset.** While `rst_n=0`, all of the following hold immediately, independent of the clock:
  - `an` all-ones, `seg=7'h7F`, `dp=1`
  - `cnt=0`, `idx=0`
  - snapshot value, dp and blank_lz all 0
- **Reset release.** Scanning resumes from slot 0 with `cnt=0`. A reset in mid-scan aborts the slot with no residual anode.

## Timing
- All outputs are registered: outputs after edge k reflect `cnt`, `idx` and the snapshot as they stood before edge k.
- **Load latency.** `load` at edge k updates the snapshot at k. The new glyph appears at edge k+1 if that cycle is active for the digit.
- **Load and slot change together.** If `load` and a slot change happen at the same edge, the snapshot and `idx` both update. The following guard cycle hides any transition.
- **Frame timing.** Frame period is `DIGITS*REFRESH_DIV` clocks. Each digit is lit for `REFRESH_DIV`-1 clocks per frame.
- **Load during a lit digit.** A load while a digit is lit changes that digit's glyph mid-slot; the change is permitted and appears one cycle later.
- `value`, `dp_in` and `blank_lz` need to be stable only in the `load` cycle.

## Test plan
All scenarios use `DIGITS=4` and `REFRESH_DIV=4`.
- **Reset.** Assert `rst_n=0` mid-slot with digit 2 lit → in the same cycle `an=1111`, `seg=1111111`, `dp=1`. After release, the first lit slot is digit 0 at the second clock.
- **Basic scan, `HEX_EN=1`.** `load` with `value=16'h1234`, `dp_in=0` → repeating pattern per slot:
  - one guard cycle (`an=1111`), then three cycles of the digit's drive.
  - digit 0: `an=1110`, `seg=1001100`
  - digit 1: `an=1101`, `seg=0000110`
  - digit 2: `an=1011`, `seg=0010010`
  - digit 3: `an=0111`, `seg=1001111`
  - frame period is 16 clocks.
- **Hex mode.** `value=16'hAF0C`, `HEX_EN=1` → digits 0..3 show 0110001, 0000001, 0111000, 0001000. Rebuild with `HEX_EN=0` → digits 0, 2 and 3 show 1111111; digit 1 shows 0000001.
- **Leading-zero suppression.** `value=16'h0050`, `blank_lz=1`, `dp_in=4'b1000`:
  - digits 3 and 2: `an=1111`, `dp=1`
  - digit 1: `seg=0100100`
  - digit 0: `seg=0000001`
  - With `value=16'h0000`, only digit 0 is lit, showing 0000001.
- **Decimal point.** `dp_in=4'b0100`, `value=16'h8888` → `dp=0` only during digit 2 active cycles; `dp=1` in guard cycles.
- **Tear-free update.** Change `value` without `load` → display is unchanged. `load` during a digit 1 active cycle → the new glyph appears on the next cycle. No other digit changes before its own slot.

Source files
------------

// File: rtl/seven_seg_mux.sv
// Time-multiplexed common-anode seven-segment driver. A load strobe snapshots the display data,
// and one digit is scanned per refresh slot. The first cycle of every slot is blanked.
module seven_seg_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int HEX_EN      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] snap_value;
  logic [DIGITS-1:0]   snap_dp;
  logic                snap_blank_lz;

  logic [DIGITS-1:0]   supp;
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic [DIGITS-1:0]   an_next;
  logic [6:0]          seg_next;
  logic                dp_next;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0001100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    if (n >= 4'hA && HEX_EN == 0) g = 7'h7F;
    return g;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_value    <= '0;
      snap_dp       <= '0;
      snap_blank_lz <= 1'b0;
    end else if (load) begin
      snap_value    <= value;
      snap_dp       <= dp_in;
      snap_blank_lz <= blank_lz;
    end
  end

  // A digit is suppressed only when it and every more-significant nibble are zero.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (snap_value[4*i +: 4] == 4'h0);
      supp[i]  = snap_blank_lz & zero_run;
    end
  end

  always_comb begin
    cur_nib  = snap_value[4*int'(idx) +: 4];
    an_next  = '1;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (cnt != '0 && !supp[idx]) begin
      an_next  = ~(DIGITS'(1) << idx);
      seg_next = glyph(cur_nib);
      dp_next  = ~snap_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Scoreboard bench for seven_seg_mux (DIGITS=4, REFRESH_DIV=4), HEX_EN=1 and HEX_EN=0 side by side.
// Stimulus pushes hand-computed expectations that are tagged by cycle. A negedge monitor pops and compares them.
module tb_seven_seg_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  an1, an0;
  logic [6:0]  seg1, seg0;
  logic        dp1, dp0;

  seven_seg_mux #(.DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
    .load(load), .an(an1), .seg(seg1), .dp(dp1));

  seven_seg_mux #(.DIGITS(4), .REFRESH_DIV(4), .HEX_EN(0)) dut_dec (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
    .load(load), .an(an0), .seg(seg0), .dp(dp0));

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] s1;
    logic [6:0] s0;
    logic       dp;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   k = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Glyph constants, packed per digit as {d3,d2,d1,d0}.
  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010, G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100, G5 = 7'b0100100, G8 = 7'b0000000;
  localparam logic [6:0] GA = 7'b0001000, GC = 7'b0110001, GF = 7'b0111000, GX = 7'h7F;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) k = 0; else k++;
  end

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.tag, e.cyc, cyc);
      end else if (an1 !== e.an || an0 !== e.an || seg1 !== e.s1 || seg0 !== e.s0 ||
                   dp1 !== e.dp || dp0 !== e.dp) begin
        n_bad++;
        $display("FAIL %s cyc %0d: got an=%b/%b seg=%b/%b dp=%b/%b, want an=%b seg=%b/%b dp=%b",
                 e.tag, cyc, an1, an0, seg1, seg0, dp1, dp0, e.an, e.s1, e.s0, e.dp);
      end
    end
  end

  task automatic push_off(input string tag);
    exp_t e;
    e.cyc = cyc; e.an = 4'hF; e.s1 = GX; e.s0 = GX; e.dp = 1'b1; e.tag = tag;
    q.push_back(e);
  endtask

  // Expected drive for the cycle after the latest edge; slot position comes from edges since reset.
  task automatic push_exp(input string tag, input logic [27:0] g1, input logic [27:0] g0,
                          input logic [3:0] lit, input logic [3:0] dpv);
    exp_t e;
    int c, d;
    c = (k - 1) % 4;
    d = ((k - 1) / 4) % 4;
    e.cyc = cyc; e.tag = tag;
    if (c == 0 || !lit[d]) begin
      e.an = 4'hF; e.s1 = GX; e.s0 = GX; e.dp = 1'b1;
    end else begin
      e.an = ~(4'b0001 << d);
      e.s1 = g1[d*7 +: 7];
      e.s0 = g0[d*7 +: 7];
      e.dp = ~dpv[d];
    end
    q.push_back(e);
  endtask

  task automatic check_frame(input string tag, input logic [27:0] g1, input logic [27:0] g0,
                             input logic [3:0] lit, input logic [3:0] dpv);
    for (int n = 0; n < 16; n++) begin
      @(posedge clk); #1;
      push_exp(tag, g1, g0, lit, dpv);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpi, input logic blz);
    @(posedge clk); #1;
    value = v; dp_in = dpi; blank_lz = blz; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    push_off("reset_state");
    @(posedge clk); #3;
    rst_n = 1'b1;
    check_frame("post_reset", {4{G0}}, {4{G0}}, 4'hF, 4'h0);

    do_load(16'h1234, 4'h0, 1'b0);
    check_frame("scan_1234", {G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'hF, 4'h0);

    do_load(16'hAF0C, 4'h0, 1'b0);
    check_frame("hex_af0c", {GA, GF, G0, GC}, {GX, GX, G0, GX}, 4'hF, 4'h0);

    do_load(16'h0050, 4'b1000, 1'b1);
    check_frame("lz_0050", {G0, G0, G5, G0}, {G0, G0, G5, G0}, 4'b0011, 4'b1000);

    do_load(16'h0000, 4'h0, 1'b1);
    check_frame("lz_0000", {4{G0}}, {4{G0}}, 4'b0001, 4'h0);

    do_load(16'h8888, 4'b0100, 1'b0);
    check_frame("dp_8888", {4{G8}}, {4{G8}}, 4'hF, 4'b0100);

    value = 16'h1234; dp_in = 4'h0;
    check_frame("no_load_hold", {4{G8}}, {4{G8}}, 4'hF, 4'b0100);

    // Load while digit 1 is in its first active cycle.
    for (int n = 0; n < 16; n++) begin
      @(posedge clk); #1;
      if ((k - 1) % 16 == 5) break;
    end
    push_exp("midslot_old", {4{G8}}, {4{G8}}, 4'hF, 4'b0100);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    push_exp("midslot_old2", {4{G8}}, {4{G8}}, 4'hF, 4'b0100);
    check_frame("midslot_new", {G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'hF, 4'h0);

    // Asynchronous reset while digit 2 is lit.
    for (int n = 0; n < 16; n++) begin
      @(posedge clk); #1;
      if ((k - 1) % 16 == 9) break;
    end
    push_exp("pre_reset_d2", {G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'hF, 4'h0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    push_off("async_reset");
    @(posedge clk); #1;
    push_off("reset_hold");
    @(posedge clk); #3;
    rst_n = 1'b1;
    check_frame("restart", {4{G0}}, {4{G0}}, 4'hF, 4'h0);

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      n_bad += q.size();
      $display("FAIL leftover: %0d expectations unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
